// File: rtl/i2c_init_seq.sv
// Table-driven I2C initialisation sequencer. Walks a ROM of {op, reg, data} entries after
// `start`, issues one transaction per entry to the single-byte I2C core, checks the result
// and retries a failed entry after pulsing the core reset.
module i2c_init_seq #(
    parameter logic [6:0]  DEV_ADDR     = 7'h36,
    parameter int unsigned TBL_AW       = 6,
    parameter int unsigned RQT_HOLD     = 4,
    parameter int unsigned DLY_UNIT     = 27000,
    parameter int unsigned TIMEOUT      = 200000,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned CORE_RST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [17:0]       tbl_data,
    output logic              i2c_rqt,
    output logic              cmd,
    output logic [6:0]        addr_dev,
    output logic [7:0]        addr_reg_L,
    output logic [7:0]        data_wr_L,
    input  logic [7:0]        data_rd,
    input  logic              data_rdy,
    input  logic              error,
    input  logic              i2c_done,
    output logic              core_rst_n,
    output logic              busy,
    output logic              seq_done,
    output logic              seq_fail,
    output logic [TBL_AW-1:0] fail_idx
);

    localparam logic [31:0]       RqtHoldW  = 32'(RQT_HOLD);
    localparam logic [31:0]       DlyUnitW  = 32'(DLY_UNIT);
    localparam logic [31:0]       TimeoutW  = 32'(TIMEOUT);
    localparam logic [31:0]       CrstLenW  = 32'(CORE_RST_LEN);
    localparam logic [7:0]        MaxRetryW = 8'(MAX_RETRY);
    localparam logic [TBL_AW-1:0] IdxMax    = '1;

    localparam logic [1:0] OpWrite = 2'b00;
    localparam logic [1:0] OpRead  = 2'b01;
    localparam logic [1:0] OpDelay = 2'b10;
    localparam logic [1:0] OpEnd   = 2'b11;

    typedef enum logic [3:0] {
        StIdle, StFetch, StDecode, StReq, StWait, StGap,
        StDelay, StErr, StCoreRst, StDone, StFail
    } state_e;

    state_e            state_q, state_d;
    logic [TBL_AW-1:0] idx_q, idx_d;
    logic [7:0]        retry_q, retry_d;
    logic [1:0]        op_q, op_d;
    logic [7:0]        fld_q, fld_d;     // data / compare value / delay ticks of current entry
    logic [31:0]       cnt_q, cnt_d;     // shared: request hold, core reset, delay unit
    logic [7:0]        tick_q, tick_d;
    logic [31:0]       to_q, to_d;
    logic              done_q, done_d;
    logic [7:0]        rd_q, rd_d;
    logic              rqt_q, rqt_d;
    logic              cmd_q, cmd_d;
    logic [7:0]        reg_q, reg_d;
    logic [7:0]        wr_q, wr_d;
    logic              crst_q, crst_d;
    logic              busy_q, busy_d;
    logic              sdone_q, sdone_d;
    logic              sfail_q, sfail_d;
    logic [TBL_AW-1:0] fidx_q, fidx_d;
    logic [7:0]        rd_now;

    assign tbl_addr   = idx_q;
    assign i2c_rqt    = rqt_q;
    assign cmd        = cmd_q;
    assign addr_dev   = DEV_ADDR;
    assign addr_reg_L = reg_q;
    assign data_wr_L  = wr_q;
    assign core_rst_n = crst_q;
    assign busy       = busy_q;
    assign seq_done   = sdone_q;
    assign seq_fail   = sfail_q;
    assign fail_idx   = fidx_q;

    // A read strobe coinciding with the done edge must still feed the compare.
    assign rd_now = data_rdy ? data_rd : rd_q;

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            retry_q <= '0;
            op_q    <= OpWrite;
            fld_q   <= '0;
            cnt_q   <= '0;
            tick_q  <= '0;
            to_q    <= '0;
            done_q  <= 1'b0;
            rd_q    <= '0;
            rqt_q   <= 1'b0;
            cmd_q   <= 1'b1;
            reg_q   <= '0;
            wr_q    <= '0;
            crst_q  <= 1'b1;
            busy_q  <= 1'b0;
            sdone_q <= 1'b0;
            sfail_q <= 1'b0;
            fidx_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            op_q    <= op_d;
            fld_q   <= fld_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            to_q    <= to_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            rqt_q   <= rqt_d;
            cmd_q   <= cmd_d;
            reg_q   <= reg_d;
            wr_q    <= wr_d;
            crst_q  <= crst_d;
            busy_q  <= busy_d;
            sdone_q <= sdone_d;
            sfail_q <= sfail_d;
            fidx_q  <= fidx_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        op_d    = op_q;
        fld_d   = fld_q;
        cnt_d   = cnt_q;
        tick_d  = tick_q;
        to_d    = to_q;
        done_d  = i2c_done;
        rd_d    = data_rdy ? data_rd : rd_q;
        rqt_d   = 1'b0;
        cmd_d   = cmd_q;
        reg_d   = reg_q;
        wr_d    = wr_q;
        crst_d  = 1'b1;
        busy_d  = busy_q;
        sdone_d = sdone_q;
        sfail_d = sfail_q;
        fidx_d  = fidx_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    idx_d   = '0;
                    retry_d = '0;
                    sdone_d = 1'b0;
                    sfail_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StFetch;
                end
            end
            StFetch: state_d = StDecode;
            StDecode: begin
                op_d   = tbl_data[17:16];
                fld_d  = tbl_data[7:0];
                cnt_d  = '0;
                tick_d = '0;
                to_d   = '0;
                unique case (tbl_data[17:16])
                    OpEnd:   state_d = StDone;
                    OpDelay: state_d = StDelay;
                    default: begin
                        cmd_d   = (tbl_data[17:16] == OpWrite);
                        reg_d   = tbl_data[15:8];
                        wr_d    = tbl_data[7:0];
                        state_d = StReq;
                    end
                endcase
            end
            StReq: begin
                rqt_d = 1'b1;
                cnt_d = cnt_q + 32'd1;
                to_d  = to_q + 32'd1;
                if (cnt_q == RqtHoldW - 32'd1) state_d = StWait;
            end
            StWait: begin
                to_d = to_q + 32'd1;
                if (i2c_done && !done_q) begin
                    if (error) state_d = StErr;
                    else if (op_q == OpRead && rd_now != fld_q) state_d = StErr;
                    else state_d = StGap;
                end else if (to_q >= TimeoutW - 32'd1) begin
                    state_d = StErr;
                end
            end
            StGap: begin
                // Core must be back in idle before the next request edge.
                if (!i2c_done) begin
                    retry_d = '0;
                    if (idx_q == IdxMax) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StFetch;
                    end
                end
            end
            StDelay: begin
                if (fld_q == 8'd0 ||
                    (tick_q == fld_q - 8'd1 && cnt_q == DlyUnitW - 32'd1)) begin
                    retry_d = '0;
                    if (idx_q == IdxMax) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StFetch;
                    end
                end else if (cnt_q == DlyUnitW - 32'd1) begin
                    cnt_d  = '0;
                    tick_d = tick_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StErr: begin
                if (retry_q < MaxRetryW) begin
                    retry_d = retry_q + 8'd1;
                    cnt_d   = '0;
                    state_d = StCoreRst;
                end else begin
                    sfail_d = 1'b1;
                    fidx_d  = idx_q;
                    state_d = StFail;
                end
            end
            StCoreRst: begin
                cnt_d  = cnt_q + 32'd1;
                crst_d = (cnt_q >= CrstLenW);
                if (cnt_q == CrstLenW) state_d = StFetch;
            end
            StDone: begin
                sdone_d = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            StFail: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: doc/i2c_init_seq.md
Name: i2c_init_seq

Overview:
- Table-driven sequencer that owns the single-byte I2C master core (`i2c_core`) and replays a register-initialisation list after reset, e.g. for sensor/PHY bring-up at 27 MHz.
- Fetches entries from an external synchronous ROM and issues one core transaction per entry. Entry types: write, read-compare, delay, end.
- Detects NACK, compare-mismatch and timeout. Retries a failed entry by pulsing the core reset. Reports done/fail status to the system controller.

Parameters:
- DEV_ADDR, 7'h36: 7-bit slave address driven to the core.
- TBL_AW, 6: table address width; the table holds at most 2^TBL_AW entries.
- RQT_HOLD, 4: cycles `i2c_rqt` is held high. Must be ≥3 to pass the core's 2-flop synchroniser.
- DLY_UNIT, 27000: clk cycles per delay tick (1 ms at 27 MHz).
- TIMEOUT, 200000: maximum cycles from request to core done before the entry is declared failed.
- MAX_RETRY, 3: retries per entry after the first attempt.
- CORE_RST_LEN, 4: cycles `core_rst_n` is held low on retry.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins the sequence at entry 0
- tbl_addr  out  TBL_AW  ROM address
- tbl_data  in  18  ROM data, valid one cycle after `tbl_addr`. Fields: [17:16] op (00 write, 01 read-compare, 10 delay, 11 end), [15:8] reg, [7:0] data/ticks
- i2c_rqt  out  1  core request level
- cmd  out  1  core command: 1 = write, 0 = read
- addr_dev  out  7  equals DEV_ADDR
- addr_reg_L  out  8  register address
- data_wr_L  out  8  write data
- data_rd  in  8  core read data
- data_rdy  in  1  core read strobe (one cycle)
- error  in  1  core sticky NACK flag
- i2c_done  in  1  core done; level, high during the core's FINISH state
- core_rst_n  out  1  registered active-low reset for the core; AND-ed with `rst_n` at the integration level
- busy  out  1  sequence running
- seq_done  out  1  sticky success flag
- seq_fail  out  1  sticky failure flag
- fail_idx  out  TBL_AW  index of the entry that exhausted its retries

Behaviour:
- Reset values:
  - tbl_addr = 0, i2c_rqt = 0, cmd = 1, addr_reg_L = 0, data_wr_L = 0, fail_idx = 0.
  - core_rst_n = 1, busy = 0, seq_done = 0, seq_fail = 0.
  - Internal: retry counter 0, state IDLE.
- All outputs are registered. `addr_dev` is the constant DEV_ADDR.

State machine:
- IDLE:
  - On `start`: index := 0, retry := 0, clear seq_done/seq_fail, busy := 1, go to FETCH.
  - `start` while busy is ignored.
- FETCH: drive `tbl_addr` = index; next cycle go to DECODE.
- DECODE: latch `tbl_data`.
  - op 11 → DONE.
  - op 10 → DELAY; data = 0 is zero ticks (one-cycle pass-through).
  - op 00 / 01 → REQ, with cmd = (op == 00), addr_reg_L = reg, data_wr_L = data.
- REQ:
  - `i2c_rqt` high for exactly RQT_HOLD cycles, then low.
  - Go to WAIT; the timeout counter starts at the first REQ cycle.
- WAIT:
  - Latch `data_rd` on `data_rdy`.
  - On the rising edge of `i2c_done` (registered compare):
    - error = 1 → ERR.
    - op 01 with latched data ≠ data field → ERR.
    - otherwise → GAP.
  - Timeout counter reaches TIMEOUT → ERR.
  - If `error` and the `i2c_done` edge occur in the same cycle, error wins.
- GAP:
  - Wait for `i2c_done` = 0, so the core has returned to IDLE before the next request.
  - Then index += 1, retry := 0, → FETCH.
  - If index = 2^TBL_AW − 1 with no end entry reached → DONE; index does not wrap.
- DELAY: count data × DLY_UNIT cycles, then index += 1 → FETCH.
- ERR:
  - retry < MAX_RETRY: retry += 1, → CORE_RST.
  - otherwise: seq_fail := 1, fail_idx := index, → FAIL.
- CORE_RST:
  - `core_rst_n` low for CORE_RST_LEN cycles. This clears the core's sticky error and its FSM.
  - Then one cycle high, then FETCH with the same index.
- DONE: seq_done := 1, busy := 0 → IDLE.
- FAIL: busy := 0 → IDLE.
  - A new `start` restarts from entry 0 and clears both flags.
- Asserting `rst_n` mid-operation returns every state and output to its reset value immediately.
  - The core is reset by the same `rst_n`; no transaction resumes.
- Latency: from `start` to `i2c_rqt` rising = 3 cycles (FETCH, DECODE, REQ registered).

Test Plan:
1. Table {W 0x10←0xA5, W 0x11←0x5A, END}, slave ACKs all → two write transactions with those reg/data values, seq_done = 1, busy falls, `i2c_rqt` high exactly 4 cycles each time.
2. Table {R-cmp 0x20 = 0x3C, END}, model returns 0x3C → seq_done = 1. Model returns 0x3D every time → 4 attempts, 3 `core_rst_n` pulses of 4 cycles each, seq_fail = 1, fail_idx = 0.
3. Slave NACKs the address on the first attempt of entry 1 only → one `core_rst_n` pulse, entry 1 reissued with identical fields, seq_done = 1, seq_fail = 0.
4. Table {DELAY 2, W 0x01←0x01, END}, DLY_UNIT reduced to 100 → `i2c_rqt` rises 200 + 3 cycles (±1) after DECODE of entry 0.
5. Core model never asserts `i2c_done`, TIMEOUT = 1000 → ERR after 1000 cycles, 3 retries, seq_fail = 1. Also check: `start` pulsed while busy has no effect.
6. `rst_n` asserted during WAIT of entry 2 → all outputs at reset values same cycle. A subsequent `start` replays from entry 0.
